pacman_mover: RTL and testbench

Upstream game-logic stage feeding the map RAM port: on each movement tick, probes the 21×21 tile map for Pac-Man's next cell, blocks on walls, wraps at the tunnel edges, consumes orbs by writing a black tile back, and accumulates score. It shares the map port with the display scanner through an external mux selected by `map_sel`. Pac-Man's cell position is output for the sprite overlay.

---
 rtl/pacman_mover.sv | 128 ++++++++++++
 tb/tb_pacman_mover.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_mover.sv
// pacman_mover: per-tick map probe, wall blocking, tunnel wrap and orb consumption for Pac-Man.
// Shares the map RAM port with the display scanner; map_sel claims it from RD through WRITE.
module pacman_mover #(
    parameter int          START_X      = 10,
    parameter int          START_Y      = 15,
    parameter int          READ_LATENCY = 2,
    parameter logic [8:0]  ORB_TOTAL    = 9'd180
) (
    input  logic        clock_50,
    input  logic        resetn,
    input  logic        step,
    input  logic [3:0]  dir_in,
    input  logic [2:0]  map_q,
    output logic [4:0]  map_x,
    output logic [4:0]  map_y,
    output logic [2:0]  map_data,
    output logic        map_wren,
    output logic        map_sel,
    output logic [4:0]  pac_x,
    output logic [4:0]  pac_y,
    output logic [1:0]  pac_dir,
    output logic [15:0] score,
    output logic [8:0]  orbs_left,
    output logic        level_clear,
    output logic        power_pulse,
    output logic        step_done
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, DECIDE, WRITE, DONE} state_t;

    localparam logic [7:0] WAIT_LOAD = 8'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

    state_t      state;
    logic [1:0]  try_dir;
    logic [1:0]  req_dir;
    logic [7:0]  wait_cnt;
    logic        big_orb;
    logic [9:0]  req_tgt;
    logic [9:0]  pac_tgt;
    logic [16:0] score_sum;

    // Neighbour cell in heading d with wrap at both tunnel edges; returns {x, y}.
    function automatic logic [9:0] target(input logic [1:0] d, input logic [4:0] x, input logic [4:0] y);
        return d == 2'd0 ? {(x == 5'd20 ? 5'd0 : x + 5'd1), y} :
               d == 2'd1 ? {(x == 5'd0 ? 5'd20 : x - 5'd1), y} :
               d == 2'd2 ? {x, (y == 5'd20 ? 5'd0 : y + 5'd1)} :
                           {x, (y == 5'd0 ? 5'd20 : y - 5'd1)};
    endfunction

    assign req_dir     = dir_in[3] ? 2'd3 : dir_in[2] ? 2'd2 : dir_in[1] ? 2'd1 : dir_in[0] ? 2'd0 : pac_dir;
    assign req_tgt     = target(req_dir, pac_x, pac_y);
    assign pac_tgt     = target(pac_dir, pac_x, pac_y);
    assign score_sum   = {1'b0, score} + (big_orb ? 17'd50 : 17'd10);
    assign map_data    = 3'b000;
    assign level_clear = orbs_left == 9'd0;

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            try_dir     <= 2'd1;
            wait_cnt    <= 8'd0;
            big_orb     <= 1'b0;
            map_x       <= 5'd0;
            map_y       <= 5'd0;
            map_wren    <= 1'b0;
            map_sel     <= 1'b0;
            pac_x       <= 5'(START_X);
            pac_y       <= 5'(START_Y);
            pac_dir     <= 2'd1;
            score       <= 16'd0;
            orbs_left   <= ORB_TOTAL;
            power_pulse <= 1'b0;
            step_done   <= 1'b0;
        end else begin
            map_wren    <= 1'b0;
            power_pulse <= 1'b0;
            step_done   <= 1'b0;
            case (state)
                IDLE: if (step) begin
                    try_dir        <= req_dir;
                    {map_x, map_y} <= req_tgt;
                    map_sel        <= 1'b1;
                    state          <= RD;
                end
                RD: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= READ_LATENCY > 1 ? WAIT : DECIDE;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 8'd1;
                    if (wait_cnt == 8'd0) state <= DECIDE;
                end
                DECIDE: if (map_q <= 3'd2) begin
                    // map_x/map_y still hold the probed cell, which becomes the new position
                    pac_x   <= map_x;
                    pac_y   <= map_y;
                    pac_dir <= try_dir;
                    big_orb <= map_q == 3'd1;
                    if (map_q != 3'd0) begin
                        map_wren    <= 1'b1;
                        power_pulse <= map_q == 3'd1;
                        state       <= WRITE;
                    end else begin
                        map_sel   <= 1'b0;
                        step_done <= 1'b1;
                        state     <= DONE;
                    end
                end else if (try_dir != pac_dir) begin
                    try_dir        <= pac_dir;
                    {map_x, map_y} <= pac_tgt;
                    state          <= RD;
                end else begin
                    map_sel   <= 1'b0;
                    step_done <= 1'b1;
                    state     <= DONE;
                end
                WRITE: begin
                    score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    orbs_left <= orbs_left - 9'(orbs_left != 9'd0);
                    map_sel   <= 1'b0;
                    step_done <= 1'b1;
                    state     <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pacman_mover.sv
// tb_pacman_mover: scoreboard bench for pacman_mover with a 2-cycle map RAM model and a reference mover.
module tb_pacman_mover;
    logic        clock_50;
    logic        resetn;
    logic        step;
    logic [3:0]  dir_in;
    logic [2:0]  map_q;
    logic [4:0]  map_x;
    logic [4:0]  map_y;
    logic [2:0]  map_data;
    logic        map_wren;
    logic        map_sel;
    logic [4:0]  pac_x;
    logic [4:0]  pac_y;
    logic [1:0]  pac_dir;
    logic [15:0] score;
    logic [8:0]  orbs_left;
    logic        level_clear;
    logic        power_pulse;
    logic        step_done;

    pacman_mover dut (
        .clock_50(clock_50), .resetn(resetn), .step(step), .dir_in(dir_in), .map_q(map_q),
        .map_x(map_x), .map_y(map_y), .map_data(map_data), .map_wren(map_wren), .map_sel(map_sel),
        .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir), .score(score), .orbs_left(orbs_left),
        .level_clear(level_clear), .power_pulse(power_pulse), .step_done(step_done)
    );

    initial clock_50 = 1'b0;
    always #10 clock_50 = ~clock_50;

    logic [2:0] mem [21][21];
    logic [2:0] ref_map [21][21];
    logic [2:0] q1;
    logic       clr;
    logic       sreq;
    logic [4:0] sx;
    logic [4:0] sy;
    logic [2:0] sv;

    always @(posedge clock_50) begin
        q1    <= mem[map_y][map_x];
        map_q <= q1;
        if (clr) begin
            for (int i = 0; i < 21; i++)
                for (int j = 0; j < 21; j++)
                    mem[i][j] <= 3'd0;
        end else if (sreq) mem[sy][sx] <= sv;
        else if (map_wren) mem[map_y][map_x] <= map_data;
    end

    typedef struct {
        int fx, fy;
        int x, y, d;
        int sc, orbs;
        int lat;
        int wr, pp;
        int wx, wy;
    } exp_t;

    exp_t sb[$];
    int n_err = 0;
    int n_checks = 0;
    int ex, ey, ed, esc, eorb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mv(input int d, input int x, input int y, output int nx, output int ny);
        nx = x;
        ny = y;
        case (d)
            0: nx = (x + 1) % 21;
            1: nx = (x + 20) % 21;
            2: ny = (y + 1) % 21;
            default: ny = (y + 20) % 21;
        endcase
    endtask

    task automatic model_reset();
        ex = 10; ey = 15; ed = 1; esc = 0; eorb = 180;
    endtask

    task automatic model_step(input logic [3:0] din, output exp_t e);
        int d, nx, ny, t;
        d = din[3] ? 3 : din[2] ? 2 : din[1] ? 1 : din[0] ? 0 : ed;
        mv(d, ex, ey, nx, ny);
        e.fx = nx; e.fy = ny;
        e.lat = 4; e.wr = 0; e.pp = 0; e.wx = 0; e.wy = 0;
        if (ref_map[ny][nx] > 3'd2 && d != ed) begin
            e.lat += 3;
            d = ed;
            mv(d, ex, ey, nx, ny);
        end
        t = int'(ref_map[ny][nx]);
        if (t <= 2) begin
            ex = nx; ey = ny; ed = d;
            if (t != 0) begin
                e.lat += 1; e.wr = 1; e.pp = (t == 1); e.wx = nx; e.wy = ny;
                esc = esc + (t == 1 ? 50 : 10);
                if (esc > 65535) esc = 65535;
                if (eorb > 0) eorb--;
                ref_map[ny][nx] = 3'd0;
            end
        end
        e.x = ex; e.y = ey; e.d = ed; e.sc = esc; e.orbs = eorb;
    endtask

    task automatic set_tile(input int x, input int y, input int v);
        sx = 5'(x); sy = 5'(y); sv = 3'(v); sreq = 1'b1;
        ref_map[y][x] = 3'(v);
        @(posedge clock_50); #1;
        sreq = 1'b0;
    endtask

    task automatic do_step(input logic [3:0] d, input bit drop);
        exp_t e;
        exp_t got;
        int cyc, wr_n, pp_n, wx, wy, wd, pp_w;
        model_step(d, e);
        sb.push_back(e);
        dir_in = d; step = 1'b1;
        @(posedge clock_50); #1;
        step = 1'b0; dir_in = 4'd0;
        check("rd_sel", map_sel, 1);
        check("rd_addr", {map_x, map_y}, {5'(e.fx), 5'(e.fy)});
        cyc = 1; wr_n = 0; pp_n = 0; wx = 0; wy = 0; wd = 0; pp_w = 0;
        while (!step_done && cyc < 40) begin
            if (map_wren) begin
                wr_n++; wx = map_x; wy = map_y; wd = map_data; pp_w = power_pulse;
            end
            if (power_pulse) pp_n++;
            @(posedge clock_50); #1;
            cyc++;
        end
        check("done_seen", step_done, 1);
        got = sb.pop_front();
        check("latency", cyc, got.lat);
        check("pac_x", pac_x, got.x);
        check("pac_y", pac_y, got.y);
        check("pac_dir", pac_dir, got.d);
        check("score", score, got.sc);
        check("orbs_left", orbs_left, got.orbs);
        check("level_clear", level_clear, got.orbs == 0);
        check("done_sel", map_sel, 0);
        check("wr_count", wr_n, got.wr);
        check("pp_count", pp_n, got.pp);
        if (got.wr != 0) begin
            check("wr_addr", {5'(wx), 5'(wy)}, {5'(got.wx), 5'(got.wy)});
            check("wr_data", wd, 0);
            check("pp_with_wr", pp_w, got.pp);
        end
        if (drop) step = 1'b1;
        @(posedge clock_50); #1;
        step = 1'b0;
        check("done_pulse", step_done, 0);
        for (int i = 0; i < 4; i++) begin
            if (drop) check("drop_sel", map_sel, 0);
            @(posedge clock_50); #1;
        end
        if (drop) check("drop_pos", {pac_x, pac_y}, {5'(got.x), 5'(got.y)});
    endtask

    initial begin
        #10_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int tx, ty, nx, ny, cyc;
        resetn = 1'b0; step = 1'b0; dir_in = 4'd0; clr = 1'b1; sreq = 1'b0;
        sx = 5'd0; sy = 5'd0; sv = 3'd0;
        for (int i = 0; i < 21; i++)
            for (int j = 0; j < 21; j++)
                ref_map[i][j] = 3'd0;
        model_reset();
        repeat (3) @(posedge clock_50);
        #1;
        clr = 1'b0; resetn = 1'b1;
        @(posedge clock_50); #1;
        check("rst_pac_x", pac_x, 10);
        check("rst_pac_y", pac_y, 15);
        check("rst_pac_dir", pac_dir, 1);
        check("rst_score", score, 0);
        check("rst_orbs", orbs_left, 180);
        check("rst_level_clear", level_clear, 0);
        check("rst_map_addr", {map_x, map_y}, 0);
        check("rst_map_ctl", {map_wren, map_sel, map_data}, 0);
        check("rst_pulses", {power_pulse, step_done}, 0);

        do_step(4'b0000, 0);
        set_tile(10, 15, 2);
        do_step(4'b0001, 0);
        set_tile(11, 15, 1);
        do_step(4'b0001, 0);
        set_tile(11, 14, 3);
        do_step(4'b1000, 0);
        repeat (12) do_step(4'b0010, 0);
        repeat (6) do_step(4'b1000, 0);
        do_step(4'b0010, 0);
        check("wrap_x", pac_x, 20);
        set_tile(19, 9, 3);
        set_tile(20, 8, 3);
        do_step(4'b1000, 1);

        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < 4; k++) begin
                mv(k, ex, ey, nx, ny);
                set_tile(nx, ny, $urandom_range(0, 5));
            end
            do_step(4'($urandom_range(0, 15)), 0);
        end

        tx = (ex + 1) % 21; ty = ey;
        set_tile(tx, ty, 2);
        dir_in = 4'b0001; step = 1'b1;
        @(posedge clock_50); #1;
        step = 1'b0; dir_in = 4'd0;
        cyc = 0;
        while (!map_wren && cyc < 20) begin
            @(posedge clock_50); #1;
            cyc++;
        end
        check("rst_wren_seen", map_wren, 1);
        resetn = 1'b0;
        #1;
        check("rst_mid_wren", map_wren, 0);
        check("rst_mid_sel", map_sel, 0);
        check("rst_mid_pos", {pac_x, pac_y, pac_dir}, {5'd10, 5'd15, 2'd1});
        check("rst_mid_score", score, 0);
        check("rst_mid_orbs", orbs_left, 180);
        @(posedge clock_50); #1;
        check("rst_no_write", mem[ty][tx], 2);
        resetn = 1'b1;
        model_reset();
        @(posedge clock_50); #1;

        for (int n = 0; n < 1320; n++) begin
            set_tile((ex + 1) % 21, ey, 1);
            do_step(4'b0001, 0);
        end
        check("sat_score", score, 16'hFFFF);
        check("sat_orbs", orbs_left, 0);
        check("sat_level_clear", level_clear, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
